// File: rtl/dm_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller.
// Contents: bus widths, op encodings ({is_store, unsigned, size[1:0]}),
// big-endian lane offsets, enable/zero constants, FSM state type and
// op legality / alignment helpers.
package dm_access_ctrl_pkg;

    localparam int DMAddrBus = 32;
    localparam int DMDataBus = 32;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;
    localparam logic [DMDataBus-1:0] ZeroWord = '0;

    // op[3] = store, op[2] = zero-extend (loads only), op[1:0] = size
    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0001;
    localparam logic [3:0] OP_LW  = 4'b0010;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1010;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Big-endian: lane 0 is the most significant byte of the word.
    localparam logic [1:0] LANE_0 = 2'd0;
    localparam logic [1:0] LANE_1 = 2'd1;
    localparam logic [1:0] LANE_2 = 2'd2;
    localparam logic [1:0] LANE_3 = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RESP   = 3'd4
    } dm_state_e;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    function automatic logic op_aligned(input logic [3:0] op, input logic [1:0] off);
        case (op[1:0])
            SZ_HALF: return ~off[0];
            SZ_WORD: return (off == 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// Combinational big-endian lane logic.
// Ports:
//   word       in  word read from memory
//   offset     in  byte offset addr[1:0]
//   op         in  request op code
//   wdata      in  store data (low byte/halfword used for SB/SH)
//   load_val   out selected lane, sign- or zero-extended to 32 bits
//   merge_word out word with the target lane replaced by store data
module dm_lane_unit
    import dm_access_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [3:0]  op,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] merge_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel   = word[31:24];
        half_sel   = offset[1] ? word[15:0] : word[31:16];
        load_val   = word;
        merge_word = word;

        case (offset)
            LANE_0: byte_sel = word[31:24];
            LANE_1: byte_sel = word[23:16];
            LANE_2: byte_sel = word[15:8];
            LANE_3: byte_sel = word[7:0];
            default: byte_sel = word[31:24];
        endcase

        case (op[1:0])
            SZ_BYTE: load_val = op[2] ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SZ_HALF: load_val = op[2] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_val = word;
        endcase

        if (op[3]) begin
            case (op[1:0])
                SZ_BYTE: begin
                    case (offset)
                        LANE_0: merge_word[31:24] = wdata[7:0];
                        LANE_1: merge_word[23:16] = wdata[7:0];
                        LANE_2: merge_word[15:8]  = wdata[7:0];
                        LANE_3: merge_word[7:0]   = wdata[7:0];
                        default: merge_word = word;
                    endcase
                end
                SZ_HALF: begin
                    if (offset[1]) merge_word[15:0]  = wdata[15:0];
                    else           merge_word[31:16] = wdata[15:0];
                end
                // A full-word store replaces everything.
                default: merge_word = wdata;
            endcase
        end
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// MEM-stage initiator for a big-endian, byte-addressed data memory with
// async read and word-only write. Byte/halfword stores are read-modify-write.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready            request handshake: a request transfers on a
//                                  rising edge where both are high; req_ready is
//                                  high only in IDLE; req_* are ignored otherwise
//   req_op, req_addr, req_wdata    request fields (latched on acceptance)
//   resp_valid                     one-cycle completion pulse
//   resp_rdata, err_o              result and error flag, valid with resp_valid
//   busy_o                         high in every state but IDLE (pipeline stall)
//   mem_ce, mem_wrn, mem_addr,
//   mem_wdata, mem_rdata           data memory interface
//   dbg_state                      current FSM state, for observation only
// DATA_W must be 32; the lane logic is built for 32-bit words.
module dm_access_ctrl
    import dm_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = DMAddrBus,
    parameter int DATA_W = DMDataBus
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              err_o,
    output logic              busy_o,
    output logic              mem_ce,
    output logic              mem_wrn,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output dm_state_e         dbg_state
);

    dm_state_e         state_q, state_d;
    logic [3:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] merge_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic              req_ok;
    logic              ce_raw, wrn_raw;
    logic [DATA_W-1:0] load_val, merge_word;

    assign req_ok = op_legal(req_op) && op_aligned(req_op, req_addr[1:0]);

    dm_lane_unit u_lane (
        .word       (mem_rdata),
        .offset     (addr_q[1:0]),
        .op         (op_q),
        .wdata      (wdata_q),
        .load_val   (load_val),
        .merge_word (merge_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_op;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        err_q   <= ~req_ok;
                        // Stores and errors report zero data.
                        rdata_q <= ZeroWord;
                    end
                end
                ST_LOAD:   rdata_q <= load_val;
                ST_RMW_RD: merge_q <= merge_word;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        resp_valid = 1'b0;
        ce_raw     = DISABLE;
        wrn_raw    = DISABLE;
        mem_addr   = '0;
        mem_wdata  = ZeroWord;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (!req_ok)                     state_d = ST_RESP;
                    else if (!req_op[3])             state_d = ST_LOAD;
                    else if (req_op[1:0] == SZ_WORD) state_d = ST_WRITE;
                    else                             state_d = ST_RMW_RD;
                end
            end
            ST_LOAD: begin
                ce_raw   = ENABLE;
                mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
                state_d  = ST_RESP;
            end
            ST_RMW_RD: begin
                ce_raw   = ENABLE;
                mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
                state_d  = ST_WRITE;
            end
            ST_WRITE: begin
                ce_raw    = ENABLE;
                wrn_raw   = ENABLE;
                mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
                mem_wdata = (op_q[1:0] == SZ_WORD) ? wdata_q : merge_q;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset must kill an in-flight write before the edge that would commit it.
    assign mem_ce     = ce_raw  & ~rst;
    assign mem_wrn    = wrn_raw & ~rst;

    assign busy_o     = (state_q != ST_IDLE);
    assign req_ready  = ~busy_o;
    assign resp_rdata = rdata_q;
    assign err_o      = err_q & (state_q == ST_RESP);
    assign dbg_state  = state_q;

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- MEM-stage initiator for the byte-addressed, big-endian data memory. The data memory has an async read, a word-only write on the clock edge, and `ce`/`wrn` enables.
- Accepts load/store requests from the pipeline and performs aligned word accesses. Loads extract and sign- or zero-extend bytes and halfwords.
- SB/SH are done as read-modify-write, because the memory only writes whole words.
- Reports busy to the hazard unit and flags misaligned or illegal ops without touching memory.

Parameters:
- ADDR_W, 32, byte address width driven to memory
- DATA_W, 32, word width; fixed at 32, any other value is unsupported

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present; sampled only when req_ready=1
- req_ready  out  1  controller idle, can accept a request
- req_op  in  4  {is_store, size/sign}; encoding in shared package
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data; low byte/halfword used for SB/SH
- resp_valid  out  1  one-cycle pulse, access complete
- resp_rdata  out  32  extended load data, valid with resp_valid; 0 for stores and errors
- err_o  out  1  valid with resp_valid: misaligned or illegal op
- busy_o  out  1  state != IDLE; feeds the pipeline stall
- mem_ce  out  1  data memory enable
- mem_wrn  out  1  data memory write enable
- mem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- mem_wdata  out  32  word to memory
- mem_rdata  in  32  word from memory (combinational read)

Behaviour:
- Reset:
  - state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, err_o=0, busy_o=0.
  - mem_ce=0, mem_wrn=0, mem_addr=0, mem_wdata=0.
  - While rst is high, mem_ce and mem_wrn are forced to 0 combinationally, so an in-flight write never commits.
- Op codes:
  - LB=0000, LH=0001, LW=0010, LBU=0100, LHU=0101, SB=1000, SH=1001, SW=1010.
  - Any other code is illegal.
- Lanes (big-endian):
  - Byte offset o=addr[1:0]. Lane o occupies word bits [31-8o -: 8].
  - Halfword offset 0 is bits [31:16]; offset 2 is bits [15:0].
- Alignment and illegal ops:
  - Halfword requires addr[0]=0; word requires addr[1:0]=0.
  - A violation or illegal op goes IDLE->RESP with err_o=1 and resp_rdata=0.
  - mem_ce is never asserted for such a request.
- FSM states: IDLE, LOAD, RMW_RD, WRITE, RESP.
- IDLE:
  - On req_valid, latch op, addr and wdata.
  - Next state: any load -> LOAD; SW -> WRITE; SB/SH -> RMW_RD; error -> RESP.
- LOAD:
  - Drive mem_ce=1, mem_wrn=0 at the aligned address.
  - Register the extracted, extended lane into resp_rdata, then go to RESP.
- RMW_RD:
  - Drive mem_ce=1, mem_wrn=0.
  - Register a merge word: mem_rdata with the target lane replaced by wdata[7:0] (SB) or wdata[15:0] (SH). Then go to WRITE.
- WRITE:
  - Drive mem_ce=1, mem_wrn=1. mem_wdata is the merge word (SB/SH) or latched wdata (SW).
  - Memory commits at the clock edge ending this cycle. Then go to RESP.
- RESP:
  - resp_valid=1 for exactly one cycle, then return to IDLE.
  - A new request is accepted only from IDLE; there is no back-to-back acceptance in RESP.
- Memory outputs outside LOAD/RMW_RD/WRITE: mem_ce=0, mem_wrn=0, mem_addr=0, mem_wdata=0.
- Latency (accept edge to resp_valid cycle): load and SW = 2 cycles; SB/SH = 3 cycles; error = 1 cycle.
- busy_o=1 in every state except IDLE. req_ready = ~busy_o.
- req_* changes while busy are ignored; the latched copy is used throughout.
- Reset mid-operation returns the FSM to IDLE, drops the pending response, and suppresses the write.

Decomposition:
- Shared package (defines): op encodings, lane offsets, the DMAddrBus/DMDataBus widths, and ENABLE/DISABLE/ZeroWord.
- One combinational sub-module, dm_lane_unit:
  - Inputs: word, offset, op, wdata.
  - Outputs: extended load value and merged store word.
  - Shared by the LOAD and RMW_RD paths.
- The FSM and registers stay in dm_access_ctrl.

Test Plan:
- Zeroed memory; SW 0x12345678 @0x10 -> WRITE cycle shows mem_addr=0x10, mem_wdata=0x12345678. resp_valid 2 cycles after accept, err_o=0.
- Then LW @0x10 -> resp_rdata=0x12345678. LB @0x13 -> 0x00000078. LH @0x12 -> 0x00005678. LBU @0x10 -> 0x00000012.
- SB 0xFFFFFFAB @0x11 -> RMW: read 0x12345678, write 0x12AB5678, resp at 3 cycles. Then LB @0x11 -> 0xFFFFFFAB and LBU @0x11 -> 0x000000AB.
- SH 0x0000BEEF @0x12 -> word becomes 0x12ABBEEF. LH @0x12 -> 0xFFFFBEEF; LHU @0x12 -> 0x0000BEEF.
- LW @0x11, SH @0x13, and op=0111 -> each gives resp_valid with err_o=1 after 1 cycle. mem_ce stays 0 throughout.
- SB @0x10 with rst asserted during the WRITE cycle -> mem_wrn never seen high at a clock edge. Word stays 0x12ABBEEF; no resp_valid. After reset, req_ready=1.
